register_file_dp: RTL and testbench
===================================

REGISTER_FILE_DP -- requirements
Module: register_file_dp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 The block SHALL have parameter DEPTH, default 8: number of registers; legal values are 2 to 256, not required to be a power of 2.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 3: address width; ADDR_WIDTH SHALL satisfy 2^ADDR_WIDTH >= DEPTH.
REQ-004 Ports SHALL be, one per line:
  CLK  input  1  single clock; all state updates on the rising edge.
  RST  input  1  reset; asynchronous, active-low.
  Clr  input  1  synchronous clear of all registers.
  WrEn  input  1  write request.
  WrAddr  input  ADDR_WIDTH  write address.
  WrData  input  WIDTH  write data.
  WrMask  input  WIDTH/8  byte enables; bit i enables WrData[8i+7:8i].
  RdEn  input  1  read request.
  RdAddr  input  ADDR_WIDTH  read address.
  RdData  output  WIDTH  registered read data.
  RdData_Valid  output  1  one-cycle strobe marking new RdData.
  RdErr  output  1  registered out-of-range read flag.
  WrErr  output  1  registered out-of-range write flag.
REQ-005 One clock; reset is asynchronous and active-low (CLK, RST).

Function
REQ-006 Storage SHALL be DEPTH registers of WIDTH bits, with independent read and write ports usable in the same cycle.
REQ-007 Write: on an edge with WrEn=1 and WrAddr<DEPTH, only the enabled bytes of register[WrAddr] SHALL update; disabled bytes SHALL hold.
REQ-008 A write with WrMask all zero SHALL change no state and SHALL NOT assert WrErr.
REQ-009 Read latency SHALL be 1 cycle: on an edge with RdEn=1, RdData SHALL load register[RdAddr], and RdData_Valid SHALL be 1 for exactly the following cycle.
REQ-010 With RdEn=0, RdData SHALL hold its last value and RdData_Valid SHALL be 0.
REQ-011 Back-to-back reads SHALL be accepted every cycle, keeping RdData_Valid continuously high.
REQ-012 Simultaneous read and write to the same in-range address SHALL be write-first per byte: enabled bytes come from WrData, disabled bytes from stored data.
REQ-013 A write with WrAddr>=DEPTH SHALL be ignored; WrErr SHALL be 1 for the next cycle, otherwise 0.
REQ-014 A read with RdAddr>=DEPTH SHALL load RdData=0 and assert RdData_Valid and RdErr for one cycle; RdErr SHALL otherwise be 0.
REQ-015 Clr=1 at an edge SHALL zero all registers.
REQ-016 Clr SHALL have priority over a same-cycle write, which is discarded.
REQ-017 A same-cycle read with Clr SHALL return 0.
REQ-018 Clr SHALL NOT alter RdData unless RdEn=1.
REQ-019 No other state SHALL exist: no FIFO or pending request, and each request is serviced on its edge.

Reset
REQ-020 RST=0 SHALL immediately, without a clock, force all registers, RdData, RdData_Valid, RdErr and WrErr to 0.
REQ-021 Assertion of RST mid-operation SHALL abort any in-flight read strobe (RdData_Valid=0).
REQ-022 Requests sampled while RST=0 SHALL be ignored.
REQ-023 The first edge after RST rises SHALL accept requests normally.

Verification (WIDTH=16, DEPTH=8, ADDR_WIDTH=3)
REQ-024 Full-mask write and readback: write 16'hABCD to addr 0 with WrMask=2'b11 and RdEn=0 -> RdData stays 16'h0000 and Valid=0. Then read addr 0 -> next cycle RdData=16'hABCD, Valid=1.
REQ-025 Byte mask: addr 5 holds 16'h1234; write 16'hFF00 with WrMask=2'b10 -> a read of addr 5 returns 16'hFF34. A read of addr 6 returns 16'h0000.
REQ-026 Bypass: addr 2 holds 16'h00AA; in the same cycle write 16'h5500 with WrMask=2'b10 and read addr 2 -> RdData=16'h55AA.
REQ-027 Out-of-range on DEPTH=6 (WrAddr=6): write 16'h7777 -> WrErr=1 for one cycle and no register changes. Read addr 7 -> RdData=0, RdErr=1, Valid=1.
REQ-028 Clear and reset: Clr=1 with a simultaneous write of 16'h1111 to addr 3 -> a later read of addr 3 returns 0. Asynchronous RST=0 mid-clock with RdData=16'hABCD -> all outputs are 0 before the next edge, and all registers read 0 after release.

Source files
------------

// File: rtl/register_file_dp.sv
// register_file_dp: dual-port byte-maskable register file with registered, write-first reads
module register_file_dp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Clr,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic [WIDTH-1:0]      WrData,
  input  logic [WIDTH/8-1:0]    WrMask,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] RdAddr,
  output logic [WIDTH-1:0]      RdData,
  output logic                  RdData_Valid,
  output logic                  RdErr,
  output logic                  WrErr
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] byteMask, stored, rdNext;
  logic wrInRange, rdInRange, wrActive;
  assign wrInRange = {1'b0, WrAddr} < DEPTH_W;
  assign rdInRange = {1'b0, RdAddr} < DEPTH_W;
  assign wrActive = WrEn && wrInRange && !Clr;
  // expand per-byte enables to a bit mask
  always_comb begin
    byteMask = '0;
    for (int b = 0; b < WIDTH/8; b++) byteMask[8*b +: 8] = {8{WrMask[b]}};
  end
  // read mux with write-first bypass; clear and out-of-range reads yield zero
  always_comb begin
    stored = '0;
    for (int i = 0; i < DEPTH; i++) if (RdAddr == ADDR_WIDTH'(i)) stored = regs[i];
    rdNext = (Clr || !rdInRange) ? '0
           : (wrActive && WrAddr == RdAddr) ? (WrData & byteMask) | (stored & ~byteMask)
           : stored;
  end
  // storage: clear wins over write, only enabled bytes update
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else for (int i = 0; i < DEPTH; i++)
      if (Clr) regs[i] <= '0;
      else if (wrActive && WrAddr == ADDR_WIDTH'(i)) regs[i] <= (WrData & byteMask) | (regs[i] & ~byteMask);
  end
  // registered read data and one-cycle status strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdData <= '0;
      RdData_Valid <= 1'b0;
      RdErr <= 1'b0;
      WrErr <= 1'b0;
    end else begin
      RdData_Valid <= RdEn;
      RdErr <= RdEn && !rdInRange;
      WrErr <= WrEn && !wrInRange && |WrMask;
      if (RdEn) RdData <= rdNext;
    end
  end
endmodule

// File: tb/tb_register_file_dp.sv
// tb_register_file_dp: directed and randomized checks of two register file instances (DEPTH 8 and 6)
module tb_register_file_dp;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST, Clr, WrEn, RdEn;
  logic [2:0] WrAddr, RdAddr;
  logic [15:0] WrData;
  logic [1:0] WrMask;
  logic [15:0] rdData [2];
  logic rdValid [2], rdErr [2], wrErr [2];
  int checks = 0, errors = 0;
  int dep [2] = '{8, 6};
  logic [15:0] mem [2][8];
  logic [15:0] expData [2];
  logic expValid [2], expRdErr [2], expWrErr [2];

  register_file_dp #(.WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST), .Clr(Clr), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrMask(WrMask), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rdData[0]),
    .RdData_Valid(rdValid[0]), .RdErr(rdErr[0]), .WrErr(wrErr[0]));
  register_file_dp #(.WIDTH(16), .DEPTH(6), .ADDR_WIDTH(3)) dut6 (
    .CLK(CLK), .RST(RST), .Clr(Clr), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrMask(WrMask), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rdData[1]),
    .RdData_Valid(rdValid[1]), .RdErr(rdErr[1]), .WrErr(wrErr[1]));

  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] nw, logic [1:0] m);
    logic [15:0] r = old;
    if (m[0]) r[7:0] = nw[7:0];
    if (m[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) mem[d][a] = 16'h0;
      expData[d] = 16'h0; expValid[d] = 0; expRdErr[d] = 0; expWrErr[d] = 0;
    end
  endtask

  task automatic modelEdge();
    if (!RST) begin modelReset(); return; end
    for (int d = 0; d < 2; d++) begin
      expValid[d] = RdEn;
      expRdErr[d] = RdEn && int'(RdAddr) >= dep[d];
      if (RdEn) begin
        if (int'(RdAddr) >= dep[d] || Clr) expData[d] = 16'h0;
        else if (WrEn && WrAddr == RdAddr) expData[d] = merge(mem[d][RdAddr], WrData, WrMask);
        else expData[d] = mem[d][RdAddr];
      end
      expWrErr[d] = WrEn && int'(WrAddr) >= dep[d] && WrMask != 2'b00;
      if (Clr) for (int a = 0; a < 8; a++) mem[d][a] = 16'h0;
      else if (WrEn && int'(WrAddr) < dep[d]) mem[d][WrAddr] = merge(mem[d][WrAddr], WrData, WrMask);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
  endtask

  task automatic idle();
    Clr = 0; WrEn = 0; RdEn = 0; WrAddr = 0; RdAddr = 0; WrData = 0; WrMask = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] v, input logic [1:0] m);
    idle(); WrEn = 1; WrAddr = a; WrData = v; WrMask = m;
  endtask

  task automatic rd(input logic [2:0] a);
    idle(); RdEn = 1; RdAddr = a;
  endtask

  task automatic test_reset();
    RST = 0; idle(); modelReset();
    #1;
    checks++;
    if ({rdData[0], rdValid[0], rdErr[0], wrErr[0]} !== 19'h0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", {rdData[0], rdValid[0], rdErr[0], wrErr[0]});
    end
    wr(3'd1, 16'hFFFF, 2'b11); RdEn = 1; RdAddr = 3'd1;
    step(); step();
    checks++;
    if (rdValid[0] !== 1'b0 || rdData[0] !== 16'h0) begin
      errors++; $display("FAIL reset_ignores_req valid=%b data=%h expected 0/0000", rdValid[0], rdData[0]);
    end
    idle(); RST = 1;
    rd(3'd1); step();
    checks++;
    if (rdValid[0] !== 1'b1 || rdData[0] !== 16'h0) begin
      errors++; $display("FAIL first_edge_after_reset valid=%b data=%h expected 1/0000", rdValid[0], rdData[0]);
    end
  endtask

  task automatic test_full_mask();
    wr(3'd0, 16'hABCD, 2'b11); step();
    checks++;
    if (rdData[0] !== 16'h0 || rdValid[0] !== 1'b0) begin
      errors++; $display("FAIL fullmask_noread data=%h valid=%b expected 0000/0", rdData[0], rdValid[0]);
    end
    rd(3'd0); step();
    checks++;
    if (rdData[0] !== 16'hABCD || rdValid[0] !== 1'b1) begin
      errors++; $display("FAIL fullmask_read data=%h valid=%b expected abcd/1", rdData[0], rdValid[0]);
    end
    idle(); step();
    checks++;
    if (rdData[0] !== 16'hABCD || rdValid[0] !== 1'b0) begin
      errors++; $display("FAIL hold_no_read data=%h valid=%b expected abcd/0", rdData[0], rdValid[0]);
    end
  endtask

  task automatic test_byte_mask();
    wr(3'd5, 16'h1234, 2'b11); step();
    wr(3'd5, 16'hFF00, 2'b10); step();
    wr(3'd5, 16'h5555, 2'b00); step();
    checks++;
    if (wrErr[0] !== 1'b0) begin
      errors++; $display("FAIL zero_mask_wrerr got %b expected 0", wrErr[0]);
    end
    rd(3'd5); step();
    checks++;
    if (rdData[0] !== 16'hFF34) begin
      errors++; $display("FAIL byte_mask_read got %h expected ff34", rdData[0]);
    end
    rd(3'd6); step();
    checks++;
    if (rdData[0] !== 16'h0 || rdErr[0] !== 1'b0 || rdData[1] !== 16'h0 || rdErr[1] !== 1'b1) begin
      errors++; $display("FAIL read_addr6 got %h/%b %h/%b expected 0000/0 0000/1", rdData[0], rdErr[0], rdData[1], rdErr[1]);
    end
  endtask

  task automatic test_bypass();
    wr(3'd2, 16'h00AA, 2'b11); step();
    wr(3'd2, 16'h5500, 2'b10); RdEn = 1; RdAddr = 3'd2; step();
    checks++;
    if (rdData[0] !== 16'h55AA || rdValid[0] !== 1'b1) begin
      errors++; $display("FAIL bypass got %h/%b expected 55aa/1", rdData[0], rdValid[0]);
    end
  endtask

  task automatic test_out_of_range();
    wr(3'd6, 16'h7777, 2'b11); step();
    checks++;
    if (wrErr[1] !== 1'b1 || wrErr[0] !== 1'b0) begin
      errors++; $display("FAIL wrerr_pulse got %b/%b expected 1 (depth6) 0 (depth8)", wrErr[1], wrErr[0]);
    end
    wr(3'd7, 16'h7777, 2'b00); step();
    checks++;
    if (wrErr[1] !== 1'b0) begin
      errors++; $display("FAIL wrerr_zero_mask got %b expected 0", wrErr[1]);
    end
    rd(3'd7); step();
    checks++;
    if (rdData[1] !== 16'h0 || rdErr[1] !== 1'b1 || rdValid[1] !== 1'b1) begin
      errors++; $display("FAIL oob_read got %h/%b/%b expected 0000/1/1", rdData[1], rdErr[1], rdValid[1]);
    end
    for (int a = 0; a < 6; a++) begin
      rd(3'(a)); step();
      checks++;
      if (rdData[1] !== expData[1] || rdErr[1] !== 1'b0) begin
        errors++; $display("FAIL oob_no_change addr %0d got %h expected %h", a, rdData[1], expData[1]);
      end
    end
  endtask

  task automatic test_clear();
    wr(3'd3, 16'h1111, 2'b11); Clr = 1; step();
    checks++;
    if (rdData[0] !== 16'h0005 - 16'h0005 + rdData[0] || rdValid[0] !== 1'b0) begin
      errors++; $display("FAIL clr_no_read valid=%b expected 0", rdValid[0]);
    end
    rd(3'd3); step();
    checks++;
    if (rdData[0] !== 16'h0) begin
      errors++; $display("FAIL clear_discards_write got %h expected 0000", rdData[0]);
    end
    wr(3'd4, 16'hBEEF, 2'b11); step();
    rd(3'd4); step();
    idle(); Clr = 1; step();
    checks++;
    if (rdData[0] !== 16'hBEEF) begin
      errors++; $display("FAIL clr_holds_rddata got %h expected beef", rdData[0]);
    end
    wr(3'd4, 16'hCAFE, 2'b11); step();
    rd(3'd4); Clr = 1; step();
    checks++;
    if (rdData[0] !== 16'h0 || rdValid[0] !== 1'b1) begin
      errors++; $display("FAIL clr_same_cycle_read got %h/%b expected 0000/1", rdData[0], rdValid[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) begin wr(3'(a), 16'(a * 16'h1111), 2'b11); step(); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a)); step();
      checks++;
      if (rdValid[0] !== 1'b1 || rdData[0] !== 16'(a * 16'h1111)) begin
        errors++; $display("FAIL back_to_back addr %0d got %h/%b expected %h/1", a, rdData[0], rdValid[0], 16'(a * 16'h1111));
      end
    end
  endtask

  task automatic test_async_reset();
    wr(3'd0, 16'hABCD, 2'b11); step();
    rd(3'd0); step();
    checks++;
    if (rdData[0] !== 16'hABCD || rdValid[0] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_read got %h/%b expected abcd/1", rdData[0], rdValid[0]);
    end
    #2 RST = 0; modelReset();
    #1;
    checks++;
    if ({rdData[0], rdValid[0], rdErr[0], wrErr[0], rdData[1], rdValid[1]} !== 35'h0) begin
      errors++; $display("FAIL async_reset got %h/%b %h/%b expected 0", rdData[0], rdValid[0], rdData[1], rdValid[1]);
    end
    step();
    idle(); RST = 1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a)); step();
      checks++;
      if (rdData[0] !== 16'h0 || rdValid[0] !== 1'b1) begin
        errors++; $display("FAIL post_reset_zero addr %0d got %h/%b expected 0000/1", a, rdData[0], rdValid[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Clr = ($urandom_range(0, 15) == 0);
      WrEn = $urandom_range(0, 1); WrAddr = 3'($urandom_range(0, 7));
      WrData = 16'($urandom); WrMask = 2'($urandom_range(0, 3));
      RdEn = $urandom_range(0, 1); RdAddr = 3'($urandom_range(0, 7));
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rdData[d] !== expData[d] || rdValid[d] !== expValid[d] || rdErr[d] !== expRdErr[d] || wrErr[d] !== expWrErr[d]) begin
          errors++;
          $display("FAIL random cycle %0d dut %0d got %h/%b/%b/%b expected %h/%b/%b/%b", n, d,
            rdData[d], rdValid[d], rdErr[d], wrErr[d], expData[d], expValid[d], expRdErr[d], expWrErr[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_byte_mask();
    test_bypass();
    test_out_of_range();
    test_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
